// File: rtl/auth_req_builder.sv
// Authentication request builder: buffers host auth commands and issues one 1000-bit request at a time.
// Request rises 2 edges after acceptance; cmd_ready drops when the FIFO is full; a request is held until acked.

// Generic FIFO: write at push edge, head visible combinationally, no internal full/empty protection.
// Latency 1 edge push-to-head; caller must not push when full or pop when empty.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push_vld,
   input  logic [WIDTH-1:0]       push_dat,
   input  logic                   pop_vld,
   output logic [WIDTH-1:0]       head_dat,
   output logic [$clog2(DEPTH):0] level
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;

   always_ff @(posedge clk) begin
      if (push_vld) mem[wr_ptr] <= push_dat;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push_vld) wr_ptr <= wr_ptr + AW'(1);
         if (pop_vld)  rd_ptr <= rd_ptr + AW'(1);
         case ({push_vld, pop_vld})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase
      end
   end

   assign head_dat = mem[rd_ptr];
endmodule

module auth_req_builder #(
   parameter logic [7:0]  PROTOCOL_VERSION = 8'h01,
   parameter int          FIFO_DEPTH       = 4,
   parameter logic [15:0] MAX_CERT_LEN     = 16'd512
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        cmd_valid,
   output logic                        cmd_ready,
   input  logic [1:0]                  cmd_type,
   input  logic [1:0]                  cmd_slot,
   input  logic [15:0]                 cmd_offset,
   input  logic [15:0]                 cmd_length,
   input  logic [255:0]                cmd_nonce,
   output logic                        cmd_err,
   input  logic                        init_req_out,
   output logic                        init_req_in,
   output logic [999:0]                auth_msg_init_in,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level,
   output logic [7:0]                  req_done_count
);
   localparam int LW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [LW-1:0] FULL_LEVEL = LW'(FIFO_DEPTH);

   typedef struct packed {
      logic [1:0]   typ;
      logic [1:0]   slot;
      logic [15:0]  offset;
      logic [15:0]  length;
      logic [255:0] nonce;
   } cmd_t;

   typedef struct packed {
      logic [7:0] param2;
      logic [7:0] param1;
      logic [7:0] msg_type;
      logic [7:0] version;
   } hdr_t;

   typedef enum logic [3:0] {
      IDLE = 4'b0001,
      LOAD = 4'b0010,
      REQ  = 4'b0100,
      GAP  = 4'b1000
   } state_t;

   state_t       state;
   state_t       state_nxt;
   cmd_t         in_cmd;
   cmd_t         head_cmd;
   cmd_t         cur_cmd;
   hdr_t         hdr;
   logic [16:0]  cert_end;
   logic         cmd_bad;
   logic         push;
   logic         pop;
   logic         done;
   logic [999:0] msg_nxt;

   assign in_cmd    = {cmd_type, cmd_slot, cmd_offset, cmd_length, cmd_nonce};
   assign cmd_ready = (fifo_level != FULL_LEVEL);

   // Offset plus length is summed at 17 bits so a certificate window past 64 KiB is caught.
   assign cert_end = {1'b0, cmd_offset} + {1'b0, cmd_length};
   assign cmd_bad  = (cmd_type == 2'd3) ||
                     ((cmd_type == 2'd1) && ((cmd_length == 16'd0) ||
                                             (cmd_length > MAX_CERT_LEN) ||
                                             (cert_end > 17'h0FFFF)));
   assign push     = cmd_valid & cmd_ready & ~cmd_bad;

   sync_fifo #(
      .WIDTH ($bits(cmd_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_cmd_fifo (
      .clk      (clk),
      .rst_n    (reset),
      .push_vld (push),
      .push_dat (in_cmd),
      .pop_vld  (pop),
      .head_dat (head_cmd),
      .level    (fifo_level)
   );

   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            if (fifo_level != '0) begin
               pop       = 1'b1;
               state_nxt = LOAD;
            end
         end
         LOAD:    state_nxt = REQ;
         REQ: begin
            if (init_req_out) begin
               done      = 1'b1;
               state_nxt = GAP;
            end
         end
         GAP:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      hdr         = '0;
      hdr.version = PROTOCOL_VERSION;
      hdr.param1  = {6'b0, cur_cmd.slot};
      msg_nxt     = '0;
      case (cur_cmd.typ)
         2'd0: hdr.msg_type = 8'h81;
         2'd1: begin
            hdr.msg_type    = 8'h82;
            msg_nxt[47:32]  = cur_cmd.offset;
            msg_nxt[63:48]  = cur_cmd.length;
         end
         2'd2: begin
            hdr.msg_type    = 8'h83;
            msg_nxt[287:32] = cur_cmd.nonce;
         end
         default: hdr.msg_type = 8'h00;
      endcase
      msg_nxt[31:0] = hdr;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state            <= IDLE;
         cur_cmd          <= '0;
         auth_msg_init_in <= '0;
         cmd_err          <= 1'b0;
         req_done_count   <= '0;
      end else begin
         state   <= state_nxt;
         cmd_err <= cmd_valid & cmd_ready & cmd_bad;
         if (pop)           cur_cmd          <= head_cmd;
         if (state == LOAD) auth_msg_init_in <= msg_nxt;
         if (done)          req_done_count   <= req_done_count + 8'd1;
      end
   end

   assign init_req_in = (state == REQ);
endmodule

// File: tb/tb_auth_req_builder.sv
// Directed bench for auth_req_builder with a queue scoreboard of expected request messages.
module tb_auth_req_builder;
   logic         clk = 1'b0;
   logic         reset;
   logic         cmd_valid;
   logic         cmd_ready;
   logic [1:0]   cmd_type;
   logic [1:0]   cmd_slot;
   logic [15:0]  cmd_offset;
   logic [15:0]  cmd_length;
   logic [255:0] cmd_nonce;
   logic         cmd_err;
   logic         init_req_out;
   logic         init_req_in;
   logic [999:0] auth_msg_init_in;
   logic [2:0]   fifo_level;
   logic [7:0]   req_done_count;

   int checks   = 0;
   int passes   = 0;
   int exp_done = 0;
   logic [999:0] exp_q[$];

   always #5 clk = ~clk;

   auth_req_builder dut (
      .clk              (clk),
      .reset            (reset),
      .cmd_valid        (cmd_valid),
      .cmd_ready        (cmd_ready),
      .cmd_type         (cmd_type),
      .cmd_slot         (cmd_slot),
      .cmd_offset       (cmd_offset),
      .cmd_length       (cmd_length),
      .cmd_nonce        (cmd_nonce),
      .cmd_err          (cmd_err),
      .init_req_out     (init_req_out),
      .init_req_in      (init_req_in),
      .auth_msg_init_in (auth_msg_init_in),
      .fifo_level       (fifo_level),
      .req_done_count   (req_done_count)
   );

   function automatic logic [999:0] model(input logic [1:0] t, input logic [1:0] s,
                                          input logic [15:0] o, input logic [15:0] l,
                                          input logic [255:0] n);
      logic [999:0] m;
      logic [7:0]   code;
      m    = '0;
      code = 8'h81 + {6'b0, t};
      m[31:0] = {8'h00, 6'b0, s, code, 8'h01};
      if (t == 2'd1) m[63:32]  = {l, o};
      if (t == 2'd2) m[287:32] = n;
      return m;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
   endtask

   task automatic chk_msg(input string tag, input logic [999:0] obs, input logic [999:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: got low320=%h upper_or=%b, expected low320=%h upper_or=%b",
                  tag, obs[319:0], |obs[999:320], exp[319:0], |exp[999:320]);
   endtask

   // Drives one command, holds until accepted, returns at the negedge after the accepting edge.
   task automatic send(input logic [1:0] t, input logic [1:0] s, input logic [15:0] o,
                       input logic [15:0] l, input logic [255:0] n, input bit ok, input string tag);
      int guard = 0;
      cmd_type   = t;
      cmd_slot   = s;
      cmd_offset = o;
      cmd_length = l;
      cmd_nonce  = n;
      cmd_valid  = 1'b1;
      while (!cmd_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (guard == 50) chk({tag, "_ready_timeout"}, cmd_ready, 1);
      @(negedge clk);
      chk({tag, "_err"}, cmd_err, !ok);
      if (ok) exp_q.push_back(model(t, s, o, l, n));
   endtask

   task automatic wait_req(input string tag, input int exp_lat);
      int cyc = 0;
      logic [999:0] e;
      while (!init_req_in && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
      chk({tag, "_lat"}, cyc, exp_lat);
      if (exp_q.size() != 0) e = exp_q.pop_front();
      else e = 'x;
      chk_msg({tag, "_msg"}, auth_msg_init_in, e);
   endtask

   task automatic ack(input string tag);
      init_req_out = 1'b1;
      @(negedge clk);
      init_req_out = 1'b0;
      exp_done = (exp_done + 1) % 256;
      chk({tag, "_ack_low"}, init_req_in, 0);
      chk({tag, "_ack_cnt"}, req_done_count, exp_done);
   endtask

   task automatic rej(input logic [1:0] t, input logic [15:0] o, input logic [15:0] l, input string tag);
      send(t, 2'd1, o, l, '0, 1'b0, tag);
      chk({tag, "_lvl"}, fifo_level, 0);
      cmd_valid = 1'b0;
      @(negedge clk);
      chk({tag, "_err_once"}, cmd_err, 0);
      chk({tag, "_noreq"}, init_req_in, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      logic [255:0] nonce;
      int highs;
      int b2b_lvl[5] = '{1, 1, 2, 3, 4};

      reset = 1'b0; cmd_valid = 1'b0; cmd_type = '0; cmd_slot = '0;
      cmd_offset = '0; cmd_length = '0; cmd_nonce = '0; init_req_out = 1'b0;
      #12;
      chk("rst_req", init_req_in, 0);
      chk("rst_lvl", fifo_level, 0);
      chk("rst_err", cmd_err, 0);
      chk("rst_cnt", req_done_count, 0);
      chk_msg("rst_msg", auth_msg_init_in, '0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("rst_rdy", cmd_ready, 1);

      // Ack with nothing outstanding must be ignored.
      init_req_out = 1'b1;
      @(negedge clk);
      init_req_out = 1'b0;
      @(negedge clk);
      chk("stray_ack_cnt", req_done_count, 0);
      chk("stray_ack_req", init_req_in, 0);

      send(2'd0, 2'd2, '0, '0, '0, 1'b1, "dig");
      chk("dig_lvl", fifo_level, 1);
      cmd_valid = 1'b0;
      wait_req("dig", 2);
      chk("dig_hdr", auth_msg_init_in[23:0], 24'h028101);
      chk_msg("dig_rest", auth_msg_init_in >> 24, '0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("dig_hold_req", init_req_in, 1);
         chk_msg("dig_hold_msg", auth_msg_init_in, model(2'd0, 2'd2, '0, '0, '0));
      end
      ack("dig");
      chk_msg("dig_gap_msg", auth_msg_init_in, model(2'd0, 2'd2, '0, '0, '0));

      @(negedge clk);
      send(2'd1, 2'd1, 16'h0010, 16'h0040, '0, 1'b1, "cert");
      cmd_valid = 1'b0;
      wait_req("cert", 2);
      chk("cert_fields", auth_msg_init_in[63:32], 32'h0040_0010);
      chk("cert_type", auth_msg_init_in[15:8], 8'h82);
      ack("cert");

      rej(2'd1, 16'h0000, 16'h0000, "len0");
      rej(2'd1, 16'h0000, 16'd513, "len513");
      rej(2'd1, 16'hFFF0, 16'h0020, "ovf");
      rej(2'd3, 16'h0000, 16'h0000, "rsvd");
      repeat (4) @(negedge clk);
      chk("rej_noreq", init_req_in, 0);
      chk("rej_lvl", fifo_level, 0);

      send(2'd1, 2'd3, 16'hFDFF, 16'd512, '0, 1'b1, "maxcert");
      cmd_valid = 1'b0;
      wait_req("maxcert", 2);
      ack("maxcert");

      nonce = {32{8'hA5}};
      send(2'd2, 2'd0, '0, '0, nonce, 1'b1, "chal");
      cmd_valid = 1'b0;
      wait_req("chal", 2);
      chk_msg("chal_nonce", auth_msg_init_in[287:32], nonce);
      chk("chal_type", auth_msg_init_in[15:8], 8'h83);
      ack("chal");

      // Five back-to-back commands; the second edge pushes and pops together.
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         send(2'(i % 2), 2'(i), 16'(i * 16), 16'h0020, '0, 1'b1, $sformatf("b2b%0d", i));
         chk($sformatf("b2b%0d_lvl", i), fifo_level, b2b_lvl[i]);
      end
      chk("b2b_rdy", cmd_ready, 0);
      cmd_valid = 1'b0;
      wait_req("b2b0", 0);
      ack("b2b0");
      for (int k = 1; k < 5; k++) begin
         wait_req($sformatf("b2b%0d", k), 3);
         ack($sformatf("b2b%0d", k));
      end

      // Reset while a request is outstanding and two entries are queued.
      @(negedge clk);
      send(2'd0, 2'd0, '0, '0, '0, 1'b1, "rA");
      send(2'd0, 2'd1, '0, '0, '0, 1'b1, "rB");
      send(2'd0, 2'd2, '0, '0, '0, 1'b1, "rC");
      cmd_valid = 1'b0;
      wait_req("rA", 0);
      chk("rq_lvl", fifo_level, 2);
      #2 reset = 1'b0;
      #1;
      chk("rq_async_req", init_req_in, 0);
      chk("rq_async_lvl", fifo_level, 0);
      chk("rq_async_cnt", req_done_count, 0);
      exp_q.delete();
      exp_done = 0;
      @(negedge clk);
      reset = 1'b1;
      highs = 0;
      repeat (10) begin
         @(negedge clk);
         if (init_req_in) highs++;
      end
      chk("rq_no_replay", highs, 0);
      chk("rq_lvl_after", fifo_level, 0);

      for (int j = 0; j < 256; j++) begin
         send(2'd0, 2'(j), '0, '0, '0, 1'b1, "wrap");
         cmd_valid = 1'b0;
         wait_req("wrap", 2);
         ack("wrap");
      end
      chk("wrap_cnt", req_done_count, 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
